// File: rtl/mccpu_ctrl_if.sv
// mccpu_ctrl_if: IR fields, ALU flag and memory handshake in,
// datapath controls, debug state and instret out.
interface mccpu_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             EXTOp;
  logic             ALUSrc;
  logic [2:0]       ALUOp;
  logic [1:0]       NPCOp;
  logic [1:0]       GPRSel;
  logic [1:0]       WDSel;
  logic [2:0]       state;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite,
    output MemRead, MemWrite, EXTOp, ALUSrc,
    output ALUOp, NPCOp, GPRSel, WDSel,
    output state, illegal, mem_err, instret
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite,
    input  MemRead, MemWrite, EXTOp, ALUSrc,
    input  ALUOp, NPCOp, GPRSel, WDSel,
    input  state, illegal, mem_err, instret
  );
endinterface

// File: rtl/mccpu_ctrl.sv
// mccpu_ctrl: multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB) with instret.
// Define JAL_EN to decode jal (Op=6'h03) with a $31 link write-back.
module mccpu_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input logic          clk,
  input logic          rstn,
  mccpu_ctrl_if.master bus
);
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic [TW-1:0]    r_wait;
  logic [CNT_W-1:0] r_instret;

  logic w_rty, w_add, w_sub, w_and, w_or;
  logic w_slt, w_sltu, w_addi, w_ori;
  logic w_lw, w_sw, w_beq, w_j, w_jal, w_legal;
  logic [2:0] w_alu;
  logic [1:0] w_gpr;
  logic w_ext, w_src;

  assign w_rty  = bus.Op == 6'h00;
  assign w_add  = w_rty && (bus.Funct == 6'h20
                         || bus.Funct == 6'h21);
  assign w_sub  = w_rty && (bus.Funct == 6'h22
                         || bus.Funct == 6'h23);
  assign w_and  = w_rty && bus.Funct == 6'h24;
  assign w_or   = w_rty && bus.Funct == 6'h25;
  assign w_slt  = w_rty && bus.Funct == 6'h2a;
  assign w_sltu = w_rty && bus.Funct == 6'h2b;
  assign w_addi = bus.Op == 6'h08;
  assign w_ori  = bus.Op == 6'h0d;
  assign w_lw   = bus.Op == 6'h23;
  assign w_sw   = bus.Op == 6'h2b;
  assign w_beq  = bus.Op == 6'h04;
  assign w_j    = bus.Op == 6'h02;
`ifdef JAL_EN
  assign w_jal  = bus.Op == 6'h03;
`else
  assign w_jal  = 1'b0;
`endif
  assign w_legal = w_add | w_sub | w_and | w_or
                 | w_slt | w_sltu | w_addi | w_ori
                 | w_lw | w_sw | w_beq | w_j | w_jal;

  always_comb begin
    w_alu = 3'd0;
    w_ext = 1'b0;
    w_src = 1'b0;
    w_gpr = 2'b00;
    unique case (1'b1)
      w_add:  w_alu = 3'd1;
      w_sub:  w_alu = 3'd2;
      w_and:  w_alu = 3'd3;
      w_or:   w_alu = 3'd4;
      w_slt:  w_alu = 3'd5;
      w_sltu: w_alu = 3'd6;
      w_addi, w_lw, w_sw: begin
        w_alu = 3'd1;
        w_ext = 1'b1;
        w_src = 1'b1;
        w_gpr = 2'b01;
      end
      w_ori: begin
        w_alu = 3'd4;
        w_src = 1'b1;
        w_gpr = 2'b01;
      end
      w_beq: begin
        w_alu = 3'd2;
        w_ext = 1'b1;
      end
      default: ;
    endcase
  end

  logic w_wait, w_tmo;
  assign w_wait = (r_state == S_IF || r_state == S_MEM)
               && !bus.mem_ready;
  assign w_tmo  = (TIMEOUT > 0) && w_wait
               && (r_wait == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IF;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IF: begin
        if (w_tmo)              w_nxt = S_IF;
        else if (bus.mem_ready) w_nxt = S_ID;
      end
      S_ID: begin
        if (w_j || !w_legal) w_nxt = S_IF;
        else if (w_jal)      w_nxt = S_WB;
        else                 w_nxt = S_EXE;
      end
      S_EXE: begin
        if (w_beq)             w_nxt = S_IF;
        else if (w_lw || w_sw) w_nxt = S_MEM;
        else                   w_nxt = S_WB;
      end
      S_MEM: begin
        if (w_tmo)              w_nxt = S_IF;
        else if (bus.mem_ready) w_nxt = w_lw ? S_WB : S_IF;
      end
      S_WB:    w_nxt = S_IF;
      default: w_nxt = S_IF;
    endcase
  end

  logic w_pcw, w_irw, w_rw, w_mr, w_mw, w_ill, w_ret;

  always_comb begin
    w_pcw = 1'b0;
    w_irw = 1'b0;
    w_rw  = 1'b0;
    w_mr  = 1'b0;
    w_mw  = 1'b0;
    w_ill = 1'b0;
    w_ret = 1'b0;
    bus.EXTOp  = 1'b0;
    bus.ALUSrc = 1'b0;
    bus.ALUOp  = 3'd0;
    bus.NPCOp  = 2'b00;
    bus.GPRSel = 2'b00;
    bus.WDSel  = 2'b00;
    unique case (r_state)
      S_IF: begin
        w_mr  = 1'b1;
        w_irw = bus.mem_ready;
        w_pcw = bus.mem_ready;
      end
      S_ID: begin
        w_ill = !w_legal;
        if (w_j || w_jal) begin
          w_pcw     = 1'b1;
          bus.NPCOp = 2'b10;
        end
        w_ret = w_j;
      end
      S_EXE: begin
        bus.EXTOp  = w_ext;
        bus.ALUSrc = w_src;
        bus.ALUOp  = w_alu;
        if (w_beq && bus.Zero) begin
          w_pcw     = 1'b1;
          bus.NPCOp = 2'b01;
        end
        w_ret = w_beq;
      end
      S_MEM: begin
        bus.EXTOp = w_ext;
        w_mr  = w_lw;
        w_mw  = w_sw;
        w_ret = w_sw && bus.mem_ready;
      end
      S_WB: begin
        bus.EXTOp = w_ext;
        w_rw  = 1'b1;
        w_ret = 1'b1;
        // jal links PC into $31; lw takes the memory word into rt
        if (w_jal) begin
          bus.GPRSel = 2'b10;
          bus.WDSel  = 2'b10;
        end else begin
          bus.GPRSel = w_gpr;
          bus.WDSel  = w_lw ? 2'b01 : 2'b00;
        end
      end
      default: ;
    endcase
  end

  assign bus.PCWrite  = w_pcw & rstn;
  assign bus.IRWrite  = w_irw & rstn;
  assign bus.RegWrite = w_rw  & rstn;
  assign bus.MemRead  = w_mr  & rstn;
  assign bus.MemWrite = w_mw  & rstn;
  assign bus.illegal  = w_ill & rstn;
  assign bus.mem_err  = w_tmo & rstn;
  assign bus.state    = r_state;
  assign bus.instret  = r_instret;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_wait <= '0;
    else if (w_tmo || w_nxt != r_state)
      r_wait <= '0;
    else if (w_wait)
      r_wait <= r_wait + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_instret <= '0;
    else if (w_ret) r_instret <= r_instret + 1'b1;
  end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb_mccpu_ctrl: per-cycle expected controls queued by the driver,
// popped and compared against the DUT on the falling edge.
module tb_mccpu_ctrl;
  localparam int CNT_W = 32;

  logic clk;
  logic rstn;

  mccpu_ctrl_if #(.CNT_W(CNT_W)) ifc ();

  mccpu_ctrl #(
    .CNT_W  (CNT_W),
    .TIMEOUT(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rw, mr, mw, ext, src;
    logic [2:0] alu;
    logic [1:0] npc, gpr, wd;
    logic       ill, err;
  } ctl_t;

  typedef struct packed {
    ctl_t             c;
    logic [CNT_W-1:0] ir;
  } exp_t;

  typedef struct packed {
    logic       ok, j, jal, beq, lw, sw, ext, src;
    logic [2:0] alu;
    logic [1:0] gpr;
  } dec_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] m_ir;
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic dec_t dec(input logic [5:0] op,
                               input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin
        d.ok = 1'b1;
        case (fn)
          6'h20, 6'h21: d.alu = 3'd1;
          6'h22, 6'h23: d.alu = 3'd2;
          6'h24:        d.alu = 3'd3;
          6'h25:        d.alu = 3'd4;
          6'h2a:        d.alu = 3'd5;
          6'h2b:        d.alu = 3'd6;
          default:      d.ok  = 1'b0;
        endcase
      end
      6'h08: begin
        d.ok = 1; d.alu = 3'd1; d.ext = 1;
        d.src = 1; d.gpr = 2'b01;
      end
      6'h0d: begin
        d.ok = 1; d.alu = 3'd4;
        d.src = 1; d.gpr = 2'b01;
      end
      6'h23: begin
        d.ok = 1; d.lw = 1; d.alu = 3'd1;
        d.ext = 1; d.src = 1; d.gpr = 2'b01;
      end
      6'h2b: begin
        d.ok = 1; d.sw = 1; d.alu = 3'd1;
        d.ext = 1; d.src = 1;
      end
      6'h04: begin
        d.ok = 1; d.beq = 1; d.alu = 3'd2; d.ext = 1;
      end
      6'h02: begin
        d.ok = 1; d.j = 1;
      end
`ifdef JAL_EN
      6'h03: begin
        d.ok = 1; d.jal = 1;
      end
`endif
      default: ;
    endcase
    return d;
  endfunction

  task automatic cyc(input logic rdy, input ctl_t c);
    exp_t e;
    @(posedge clk); #1;
    ifc.Op        = cur_op;
    ifc.Funct     = cur_fn;
    ifc.Zero      = cur_z;
    ifc.mem_ready = rdy;
    e.c  = c;
    e.ir = m_ir;
    q.push_back(e);
  endtask

  // mw: MEM wait cycles; -1 = stuck until timeout; -2 = stop after one
  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int iw, input int mw);
    dec_t d;
    ctl_t c;
    d = dec(op, fn);
    cur_op = op; cur_fn = fn; cur_z = z;
    for (int i = 0; i <= iw; i++) begin
      c = '0; c.mr = 1'b1;
      if (i == iw) begin c.pcw = 1'b1; c.irw = 1'b1; end
      cyc(i == iw, c);
    end
    c = '0; c.st = 3'd1;
    if (d.j || d.jal) begin c.pcw = 1'b1; c.npc = 2'b10; end
    c.ill = !d.ok;
    cyc(1'b1, c);
    if (d.j) begin m_ir++; return; end
    if (!d.ok) return;
    if (!d.jal) begin
      c = '0; c.st = 3'd2;
      c.alu = d.alu; c.src = d.src; c.ext = d.ext;
      if (d.beq && z) begin c.pcw = 1'b1; c.npc = 2'b01; end
      cyc(1'b1, c);
      if (d.beq) begin m_ir++; return; end
      if (d.lw || d.sw) begin
        c = '0; c.st = 3'd3; c.ext = d.ext;
        c.mr = d.lw; c.mw = d.sw;
        if (mw == -2) begin cyc(1'b0, c); return; end
        if (mw == -1) begin
          for (int i = 0; i < 4; i++) begin
            c.err = (i == 3);
            cyc(1'b0, c);
          end
          return;
        end
        for (int i = 0; i <= mw; i++) cyc(i == mw, c);
        if (d.sw) begin m_ir++; return; end
      end
    end
    c = '0; c.st = 3'd4; c.rw = 1'b1; c.ext = d.ext;
    c.gpr = d.jal ? 2'b10 : d.gpr;
    c.wd  = d.lw ? 2'b01 : (d.jal ? 2'b10 : 2'b00);
    cyc(1'b1, c);
    m_ir++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      ctl_t o;
      e = q.pop_front();
      o = {ifc.state, ifc.PCWrite, ifc.IRWrite, ifc.RegWrite,
           ifc.MemRead, ifc.MemWrite, ifc.EXTOp, ifc.ALUSrc,
           ifc.ALUOp, ifc.NPCOp, ifc.GPRSel, ifc.WDSel,
           ifc.illegal, ifc.mem_err};
      chk($sformatf("ctl op%h st%0d", ifc.Op, e.c.st),
          64'(o), 64'(e.c));
      chk("instret", 64'(ifc.instret), 64'(e.ir));
    end
  end

  initial begin
    rstn = 1'b0;
    ifc.Op = '0; ifc.Funct = '0;
    ifc.Zero = 1'b0; ifc.mem_ready = 1'b0;
    cur_op = '0; cur_fn = '0; cur_z = 1'b0;
    m_ir = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 64'(ifc.state), 64'd0);
    chk("rst_memrd", 64'(ifc.MemRead), 64'd0);
    chk("rst_instret", 64'(ifc.instret), 64'd0);
    rstn = 1'b1;

    issue(6'h00, 6'h20, 1'b0, 0, 0);
    issue(6'h23, 6'h00, 1'b0, 0, 2);
    issue(6'h04, 6'h00, 1'b1, 0, 0);
    issue(6'h04, 6'h00, 1'b0, 0, 0);
    issue(6'h02, 6'h00, 1'b0, 0, 0);
    issue(6'h3f, 6'h00, 1'b0, 0, 0);
    issue(6'h03, 6'h00, 1'b0, 0, 0);
    issue(6'h2b, 6'h00, 1'b0, 0, -1);
    issue(6'h2b, 6'h00, 1'b0, 1, 0);
    issue(6'h08, 6'h00, 1'b0, 2, 0);
    issue(6'h0d, 6'h00, 1'b0, 0, 0);
    issue(6'h00, 6'h22, 1'b0, 0, 0);
    issue(6'h00, 6'h23, 1'b0, 0, 0);
    issue(6'h00, 6'h21, 1'b0, 0, 0);
    issue(6'h00, 6'h24, 1'b0, 0, 0);
    issue(6'h00, 6'h25, 1'b0, 0, 0);
    issue(6'h00, 6'h2a, 1'b0, 0, 0);
    issue(6'h00, 6'h2b, 1'b0, 0, 0);
    issue(6'h00, 6'h00, 1'b0, 0, 0);
    issue(6'h23, 6'h00, 1'b0, 1, 0);

    issue(6'h2b, 6'h00, 1'b0, 0, -2);
    @(posedge clk); #1;
    ifc.mem_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_memwr", 64'(ifc.MemWrite), 64'd0);
    chk("rst_memrd2", 64'(ifc.MemRead), 64'd0);
    chk("rst_state2", 64'(ifc.state), 64'd0);
    chk("rst_instret2", 64'(ifc.instret), 64'd0);
    m_ir = '0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    issue(6'h00, 6'h20, 1'b0, 0, 0);
    issue(6'h02, 6'h00, 1'b0, 0, 0);

    @(negedge clk); #1;
    chk("drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mccpu_ctrl.md
Name: mccpu_ctrl

Overview:
Multi-cycle successor to the single-cycle MIPS decoder. It sequences each instruction through an FSM: fetch, decode, execute, memory and write-back. Control outputs are driven per state from the IR-held Op/Funct, and memory accesses wait on a ready handshake. It sits between the IR and the multi-cycle datapath (PC, IR, RF, ALU, NPC, shared memory) and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)
TIMEOUT, 0, max cycles waiting on mem_ready before mem_err; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
rstn  in  1  async active-low reset
Op  in  6  IR[31:26], stable from ID through WB
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag, valid in EXE
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
RegWrite  out  1  RF write enable
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
EXTOp  out  1  1 = sign-extend imm16
ALUSrc  out  1  1 = ALU B from immediate
ALUOp  out  3  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLTU
NPCOp  out  2  00 PLUS4, 01 BRANCH, 10 JUMP
GPRSel  out  2  00 rd, 01 rt, 10 $31
WDSel  out  2  00 ALU, 01 MEM, 10 PC
state  out  3  current FSM state (debug)
illegal  out  1  one-cycle pulse on undecodable instruction
mem_err  out  1  one-cycle pulse on memory timeout
instret  out  CNT_W  count of retired instructions

Behaviour:
- Decode set: R-type add/sub/and/or/slt/sltu/addu/subu; addi, ori, lw, sw, beq, j. ALUOp, EXTOp, ALUSrc and GPRSel mapping as in single-cycle ctrl.
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5-7 are illegal and return to IF next cycle.
- IF: MemRead=1. On mem_ready: IRWrite=1, PCWrite=1, NPCOp=00, then go to ID. Otherwise stay in IF.
- ID:
  - j: PCWrite=1, NPCOp=10, retire, go to IF.
  - Undecodable: illegal=1, no writes, no retire, go to IF.
  - Everything else goes to EXE.
- EXE: ALUOp and ALUSrc are driven.
  - beq: PCWrite=Zero, NPCOp=01 if Zero; retire; go to IF.
  - lw/sw go to MEM. All others go to WB.
- MEM:
  - lw: MemRead=1; on mem_ready go to WB.
  - sw: MemWrite=1; on mem_ready retire and go to IF.
  - Request is held stable until mem_ready.
- WB: RegWrite=1 for one cycle, retire, go to IF. WDSel=01 and GPRSel=01 for lw; WDSel=00 otherwise.
- Outputs are combinational from state and Op/Funct. All enables and encodings are 0 in states where they are not listed. ALUOp=000 outside EXE.
- Latencies with mem_ready tied high: j 2 cycles; beq 3; R/addi/ori 4; sw 4; lw 5.
- Timeout (TIMEOUT>0):
  - A wait counter clears on every state entry and counts cycles with mem_ready low in IF/MEM.
  - When it reaches TIMEOUT: mem_err pulses, the access is abandoned, the FSM goes to IF, and there is no retire.
- instret increments by 1 on the retire cycle and wraps to 0.
- Reset (rstn low, asynchronous): state=IF, instret=0, wait counter=0.
  - While rstn is low, all write/request enables, illegal and mem_err are forced to 0.
  - Reset mid-instruction abandons it with no write.
  - The first fetch starts on the first rising edge after rstn rises.

Optional Feature:
JAL_EN:
- Defined: jal (Op=6'h03) is decoded.
  - ID: PCWrite=1, NPCOp=10, go to WB.
  - WB: RegWrite=1, GPRSel=10, WDSel=10 (return address), retire.
  - Total 3 cycles.
- Undefined: Op=6'h03 is undecodable (illegal pulse), and GPRSel/WDSel never take value 10.

Test Plan:
1. add, mem_ready=1 → states 0,1,2,4. ALUOp=001 in EXE. RegWrite=1 only in WB with GPRSel=00. instret 0→1 after 4 cycles.
2. lw with mem_ready low for 2 cycles in MEM → 7 cycles total. MemRead held high 3 cycles in MEM. WB has WDSel=01, GPRSel=01, EXTOp=1.
3. beq with Zero=1 → PCWrite=1, NPCOp=01 in EXE. With Zero=0 → PCWrite=0. Both retire after 3 cycles.
4. j → PCWrite=1, NPCOp=10 in ID, back to IF after 2 cycles. Op=6'h3F → illegal pulse in ID, no enables, instret unchanged.
5. TIMEOUT=4, sw with mem_ready stuck low → MemWrite high 4 cycles, then mem_err pulse, state=IF, instret unchanged.
6. rstn pulled low during sw MEM → MemWrite=0 in the same cycle, state=0, instret=0. After release the next fetch completes normally. With JAL_EN, jal → WB has GPRSel=10, WDSel=10.
